// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: host enumeration, host ID type and arbiter defaults.
package xbar_pkg;

    // Number of hosts that can issue requests into the crossbar.
    localparam int unsigned N_HOST = 2;

    // Default number of in-flight transactions a shared device port tracks.
    localparam int unsigned XBAR_ARB_MAX_OUTSTANDING = 2;

    // Host indices; the arbiter's round-robin scan walks this order.
    typedef enum logic [0:0] {
        TlBrqif  = 1'b0,
        TlBrqlsu = 1'b1
    } tl_host_e;

    typedef logic [$clog2(N_HOST)-1:0] host_id_t;

    // Width of a host index, never narrower than one bit.
    function automatic int unsigned id_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbar_id_fifo.sv
// In-order FIFO of host IDs for transactions accepted by a device and not yet answered.
module xbar_id_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  count_q;
    logic             push_en, pop_en;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign pop_en  = pop_i && !empty_o;
    assign push_en = push_i && (!full_o || pop_en);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop_en) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + 1'b1;
            end else if (pop_en && !push_en) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbar_host_arb.sv
// Round-robin arbiter sharing one crossbar device slot between hosts, with in-order
// response routing by host ID and a cap on in-flight transactions.
module xbar_host_arb
    import xbar_pkg::*;
#(
    parameter int unsigned NHost          = N_HOST,
    parameter int unsigned MaxOutstanding = XBAR_ARB_MAX_OUTSTANDING,
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NHost-1:0]        h_a_valid_i,
    output logic [NHost-1:0]        h_a_ready_o,
    input  logic [NHost*AW-1:0]     h_a_addr_i,
    input  logic [NHost-1:0]        h_a_we_i,
    input  logic [NHost*DW-1:0]     h_a_wdata_i,
    input  logic [NHost*(DW/8)-1:0] h_a_be_i,
    output logic [NHost-1:0]        h_d_valid_o,
    input  logic [NHost-1:0]        h_d_ready_i,
    output logic [DW-1:0]           h_d_rdata_o,
    output logic                    h_d_error_o,
    output logic                    dev_a_valid_o,
    input  logic                    dev_a_ready_i,
    output logic [AW-1:0]           dev_a_addr_o,
    output logic                    dev_a_we_o,
    output logic [DW-1:0]           dev_a_wdata_o,
    output logic [DW/8-1:0]         dev_a_be_o,
    input  logic                    dev_d_valid_i,
    output logic                    dev_d_ready_o,
    input  logic [DW-1:0]           dev_d_rdata_i,
    input  logic                    dev_d_error_i,
    output logic [CntW-1:0]         outstanding_o,
    output logic                    unexp_rsp_o
);

    localparam int unsigned IdW = id_width(NHost);
    localparam int unsigned BW  = DW / 8;

    logic [IdW-1:0] last_grant_q;
    logic           locked_q;
    logic [IdW-1:0] locked_host_q;
    logic           unexp_q;

    logic           any_req;
    logic [IdW-1:0] arb_win;
    logic [IdW-1:0] cand;
    logic [IdW-1:0] sel;
    logic           accept;

    logic           fifo_full, fifo_empty, fifo_pop;
    logic [IdW-1:0] head;

    // Round-robin scan starting just after the last granted host.
    always_comb begin
        any_req = 1'b0;
        arb_win = last_grant_q;
        cand    = '0;
        for (int unsigned k = 1; k <= NHost; k++) begin
            cand = IdW'((32'(last_grant_q) + k) % NHost);
            if (!any_req && h_a_valid_i[cand]) begin
                any_req = 1'b1;
                arb_win = cand;
            end
        end
    end

    // A stalled request keeps its host so the device sees a stable A channel.
    assign sel           = locked_q ? locked_host_q : arb_win;
    // No bypass of a same-cycle pop: keeps d_ready off the a_valid path.
    assign dev_a_valid_o = !fifo_full && (locked_q || any_req);
    assign accept        = dev_a_valid_o && dev_a_ready_i;

    // Request mux and per-host ready for the selected host.
    always_comb begin
        dev_a_addr_o  = '0;
        dev_a_we_o    = 1'b0;
        dev_a_wdata_o = '0;
        dev_a_be_o    = '0;
        h_a_ready_o   = '0;
        for (int h = 0; h < NHost; h++) begin
            if (sel == IdW'(h)) begin
                dev_a_addr_o   = h_a_addr_i[h*AW +: AW];
                dev_a_we_o     = h_a_we_i[h];
                dev_a_wdata_o  = h_a_wdata_i[h*DW +: DW];
                dev_a_be_o     = h_a_be_i[h*BW +: BW];
                h_a_ready_o[h] = accept;
            end
        end
    end

    // Route the response to the oldest outstanding host; sink it if nothing is owed.
    always_comb begin
        h_d_valid_o   = '0;
        dev_d_ready_o = 1'b1;
        if (!fifo_empty) begin
            for (int h = 0; h < NHost; h++) begin
                if (head == IdW'(h)) begin
                    h_d_valid_o[h] = dev_d_valid_i;
                    dev_d_ready_o  = h_d_ready_i[h];
                end
            end
        end
    end

    assign fifo_pop    = dev_d_valid_i && dev_d_ready_o && !fifo_empty;
    assign h_d_rdata_o = dev_d_rdata_i;
    assign h_d_error_o = dev_d_error_i;
    assign unexp_rsp_o = unexp_q;

    // Grant pointer, request lock and unexpected-response flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            last_grant_q  <= IdW'(NHost - 1);
            locked_q      <= 1'b0;
            locked_host_q <= '0;
            unexp_q       <= 1'b0;
        end else begin
            unexp_q <= dev_d_valid_i && fifo_empty;
            if (accept) begin
                locked_q     <= 1'b0;
                last_grant_q <= sel;
            end else if (dev_a_valid_o) begin
                locked_q      <= 1'b1;
                locked_host_q <= sel;
            end
        end
    end

    xbar_id_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdW),
        .CntW  (CntW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept),
        .wdata_i (sel),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding_o)
    );

endmodule

// File: tb/tb_xbar_host_arb.sv
// Bench for xbar_host_arb: scenario tasks with a queue of expected response owners.
module tb_xbar_host_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  h_a_valid, h_a_ready, h_a_we, h_d_valid, h_d_ready;
    logic [63:0] h_a_addr, h_a_wdata;
    logic [7:0]  h_a_be;
    logic [31:0] h_d_rdata, dev_a_addr, dev_a_wdata, dev_d_rdata;
    logic        h_d_error, dev_a_valid, dev_a_ready, dev_a_we;
    logic [3:0]  dev_a_be;
    logic        dev_d_valid, dev_d_ready, dev_d_error, unexp_rsp;
    logic [1:0]  outstanding;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    xbar_host_arb #(
        .NHost          (2),
        .MaxOutstanding (2),
        .AW             (32),
        .DW             (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .h_a_valid_i   (h_a_valid),
        .h_a_ready_o   (h_a_ready),
        .h_a_addr_i    (h_a_addr),
        .h_a_we_i      (h_a_we),
        .h_a_wdata_i   (h_a_wdata),
        .h_a_be_i      (h_a_be),
        .h_d_valid_o   (h_d_valid),
        .h_d_ready_i   (h_d_ready),
        .h_d_rdata_o   (h_d_rdata),
        .h_d_error_o   (h_d_error),
        .dev_a_valid_o (dev_a_valid),
        .dev_a_ready_i (dev_a_ready),
        .dev_a_addr_o  (dev_a_addr),
        .dev_a_we_o    (dev_a_we),
        .dev_a_wdata_o (dev_a_wdata),
        .dev_a_be_o    (dev_a_be),
        .dev_d_valid_i (dev_d_valid),
        .dev_d_ready_o (dev_d_ready),
        .dev_d_rdata_i (dev_d_rdata),
        .dev_d_error_i (dev_d_error),
        .outstanding_o (outstanding),
        .unexp_rsp_o   (unexp_rsp)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pops the next owed host and returns its one-hot response mask (00 if none owed).
    function automatic logic [1:0] pop_exp();
        int h;
        if (exp_q.size() == 0) return 2'b00;
        h = exp_q.pop_front();
        return (h == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        h_a_valid = '0; h_a_we = '0; h_a_addr = '0; h_a_wdata = '0; h_a_be = '0;
        h_d_ready = 2'b11; dev_a_ready = 1'b0;
        dev_d_valid = 1'b0; dev_d_rdata = '0; dev_d_error = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #4;
        total++; if (dev_a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%0b want=0", dev_a_valid); end
        total++; if (h_a_ready !== 2'b00) begin bad++; $display("FAIL reset_a_ready got=%b want=00", h_a_ready); end
        total++; if (h_d_valid !== 2'b00) begin bad++; $display("FAIL reset_d_valid got=%b want=00", h_d_valid); end
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
        total++; if (unexp_rsp !== 1'b0) begin bad++; $display("FAIL reset_unexp got=%0b want=0", unexp_rsp); end
        step();
    endtask

    task automatic test_single();
        logic [1:0] m;
        h_a_valid = 2'b10; h_a_we = 2'b10;
        h_a_addr[63:32] = 32'h1000_0004; h_a_wdata[63:32] = 32'hDEAD_BEEF; h_a_be[7:4] = 4'hF;
        dev_a_ready = 1'b1;
        #4;
        total++; if (dev_a_valid !== 1'b1) begin bad++; $display("FAIL single_a_valid got=%0b want=1", dev_a_valid); end
        total++; if (dev_a_addr !== 32'h1000_0004) begin bad++; $display("FAIL single_addr got=%h want=10000004", dev_a_addr); end
        total++; if (dev_a_we !== 1'b1) begin bad++; $display("FAIL single_we got=%0b want=1", dev_a_we); end
        total++; if (dev_a_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_wdata got=%h want=deadbeef", dev_a_wdata); end
        total++; if (dev_a_be !== 4'hF) begin bad++; $display("FAIL single_be got=%h want=f", dev_a_be); end
        total++; if (h_a_ready !== 2'b10) begin bad++; $display("FAIL single_a_ready got=%b want=10", h_a_ready); end
        exp_q.push_back(1);
        step();
        h_a_valid = 2'b00; h_a_we = 2'b00; dev_a_ready = 1'b0;
        #4;
        total++; if (outstanding !== 2'd1) begin bad++; $display("FAIL single_outstanding got=%0d want=1", outstanding); end
        step();
        dev_d_valid = 1'b1; dev_d_rdata = 32'h0;
        #4;
        m = pop_exp();
        total++; if (h_d_valid !== m) begin bad++; $display("FAIL single_d_valid got=%b want=%b", h_d_valid, m); end
        total++; if (h_d_rdata !== 32'h0) begin bad++; $display("FAIL single_rdata got=%h want=0", h_d_rdata); end
        total++; if (dev_d_ready !== 1'b1) begin bad++; $display("FAIL single_d_ready got=%0b want=1", dev_d_ready); end
        step();
        dev_d_valid = 1'b0;
        #4;
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL single_drained got=%0d want=0", outstanding); end
        step();
    endtask

    task automatic test_round_robin();
        logic [1:0] m;
        h_a_addr = {32'h0000_0200, 32'h0000_0100};
        h_a_valid = 2'b11; dev_a_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            dev_d_valid = (c > 0);
            #4;
            total++; if (h_a_ready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", c, h_a_ready, (c % 2 == 0) ? 2'b01 : 2'b10); end
            total++; if (dev_a_addr !== ((c % 2 == 0) ? 32'h100 : 32'h200)) begin bad++; $display("FAIL rr_addr%0d got=%h", c, dev_a_addr); end
            if (c > 0) begin
                m = pop_exp();
                total++; if (h_d_valid !== m) begin bad++; $display("FAIL rr_rsp%0d got=%b want=%b", c, h_d_valid, m); end
            end
            exp_q.push_back(c % 2);
            step();
        end
        h_a_valid = 2'b00; dev_a_ready = 1'b0;
        #4;
        m = pop_exp();
        total++; if (h_d_valid !== m) begin bad++; $display("FAIL rr_rsp_last got=%b want=%b", h_d_valid, m); end
        step();
        dev_d_valid = 1'b0;
        #4;
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL rr_drained got=%0d want=0", outstanding); end
        step();
    endtask

    task automatic test_stall_lock();
        logic [1:0] m;
        h_a_valid = 2'b11; dev_a_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #4;
            total++; if (dev_a_valid !== 1'b1 || dev_a_addr !== 32'h100 || h_a_ready !== 2'b00) begin bad++; $display("FAIL stall_hold%0d valid=%0b addr=%h ready=%b want 1/100/00", c, dev_a_valid, dev_a_addr, h_a_ready); end
            step();
        end
        dev_a_ready = 1'b1;
        #4;
        total++; if (h_a_ready !== 2'b01) begin bad++; $display("FAIL stall_accept0 got=%b want=01", h_a_ready); end
        exp_q.push_back(0);
        step();
        #4;
        total++; if (h_a_ready !== 2'b10 || dev_a_addr !== 32'h200) begin bad++; $display("FAIL stall_then1 ready=%b addr=%h want 10/200", h_a_ready, dev_a_addr); end
        exp_q.push_back(1);
        step();
        h_a_valid = 2'b00; dev_a_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dev_d_valid = 1'b1;
            #4;
            m = pop_exp();
            total++; if (h_d_valid !== m) begin bad++; $display("FAIL stall_rsp%0d got=%b want=%b", i, h_d_valid, m); end
            step();
        end
        dev_d_valid = 1'b0;
        // Host 1 stalls alone; host 0 joining must not steal the locked slot.
        h_a_valid = 2'b10;
        #4;
        total++; if (dev_a_addr !== 32'h200) begin bad++; $display("FAIL lock_first got=%h want=200", dev_a_addr); end
        step();
        h_a_valid = 2'b11;
        for (int c = 0; c < 2; c++) begin
            #4;
            total++; if (dev_a_addr !== 32'h200 || h_a_ready !== 2'b00) begin bad++; $display("FAIL lock_hold%0d addr=%h ready=%b want 200/00", c, dev_a_addr, h_a_ready); end
            step();
        end
        dev_a_ready = 1'b1;
        #4;
        total++; if (h_a_ready !== 2'b10) begin bad++; $display("FAIL lock_accept got=%b want=10", h_a_ready); end
        exp_q.push_back(1);
        step();
        h_a_valid = 2'b01;
        #4;
        total++; if (h_a_ready !== 2'b01) begin bad++; $display("FAIL lock_next got=%b want=01", h_a_ready); end
        exp_q.push_back(0);
        step();
        h_a_valid = 2'b00; dev_a_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            dev_d_valid = 1'b1;
            #4;
            m = pop_exp();
            total++; if (h_d_valid !== m) begin bad++; $display("FAIL lock_rsp%0d got=%b want=%b", i, h_d_valid, m); end
            step();
        end
        dev_d_valid = 1'b0;
    endtask

    task automatic test_full();
        logic [1:0] m;
        h_a_valid = 2'b11; dev_a_ready = 1'b1;
        #4;
        total++; if (h_a_ready !== 2'b10) begin bad++; $display("FAIL full_acc1 got=%b want=10", h_a_ready); end
        exp_q.push_back(1);
        step();
        #4;
        total++; if (h_a_ready !== 2'b01) begin bad++; $display("FAIL full_acc2 got=%b want=01", h_a_ready); end
        exp_q.push_back(0);
        step();
        dev_d_valid = 1'b1;
        #4;
        total++; if (outstanding !== 2'd2) begin bad++; $display("FAIL full_count got=%0d want=2", outstanding); end
        total++; if (dev_a_valid !== 1'b0 || h_a_ready !== 2'b00) begin bad++; $display("FAIL full_block valid=%0b ready=%b want 0/00", dev_a_valid, h_a_ready); end
        m = pop_exp();
        total++; if (h_d_valid !== m) begin bad++; $display("FAIL full_rsp got=%b want=%b", h_d_valid, m); end
        step();
        dev_d_valid = 1'b0;
        #4;
        total++; if (outstanding !== 2'd1) begin bad++; $display("FAIL full_after_pop got=%0d want=1", outstanding); end
        total++; if (dev_a_valid !== 1'b1 || h_a_ready !== 2'b10) begin bad++; $display("FAIL full_regrant valid=%0b ready=%b want 1/10", dev_a_valid, h_a_ready); end
        exp_q.push_back(1);
        step();
        h_a_valid = 2'b00; dev_a_ready = 1'b0;
        #4;
        total++; if (outstanding !== 2'd2) begin bad++; $display("FAIL full_refill got=%0d want=2", outstanding); end
        for (int i = 0; i < 2; i++) begin
            dev_d_valid = 1'b1;
            #4;
            m = pop_exp();
            total++; if (h_d_valid !== m) begin bad++; $display("FAIL full_drain%0d got=%b want=%b", i, h_d_valid, m); end
            step();
        end
        dev_d_valid = 1'b0;
    endtask

    task automatic test_ordering();
        logic [1:0] m;
        dev_a_ready = 1'b1;
        h_a_valid = 2'b01;
        #4;
        total++; if (h_a_ready !== 2'b01) begin bad++; $display("FAIL ord_acc0 got=%b want=01", h_a_ready); end
        exp_q.push_back(0);
        step();
        h_a_valid = 2'b10;
        #4;
        total++; if (h_a_ready !== 2'b10) begin bad++; $display("FAIL ord_acc1 got=%b want=10", h_a_ready); end
        exp_q.push_back(1);
        step();
        h_a_valid = 2'b00; dev_a_ready = 1'b0;
        h_d_ready = 2'b10; dev_d_valid = 1'b1; dev_d_rdata = 32'hA;
        #4;
        total++; if (dev_d_ready !== 1'b0) begin bad++; $display("FAIL ord_backpressure got=%0b want=0", dev_d_ready); end
        step();
        #4;
        total++; if (outstanding !== 2'd2) begin bad++; $display("FAIL ord_held got=%0d want=2", outstanding); end
        h_d_ready = 2'b11;
        #1;
        m = pop_exp();
        total++; if (h_d_valid !== m || h_d_rdata !== 32'hA) begin bad++; $display("FAIL ord_rsp0 valid=%b rdata=%h want %b/a", h_d_valid, h_d_rdata, m); end
        step();
        dev_d_rdata = 32'hB; dev_d_error = 1'b1;
        #4;
        m = pop_exp();
        total++; if (h_d_valid !== m || h_d_rdata !== 32'hB) begin bad++; $display("FAIL ord_rsp1 valid=%b rdata=%h want %b/b", h_d_valid, h_d_rdata, m); end
        total++; if (h_d_error !== 1'b1) begin bad++; $display("FAIL ord_error got=%0b want=1", h_d_error); end
        step();
        dev_d_valid = 1'b0; dev_d_error = 1'b0;
        #4;
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL ord_drained got=%0d want=0", outstanding); end
        step();
    endtask

    task automatic test_unexp_reset();
        dev_d_valid = 1'b1;
        #4;
        total++; if (dev_d_ready !== 1'b1 || h_d_valid !== 2'b00) begin bad++; $display("FAIL unexp_sink ready=%0b valid=%b want 1/00", dev_d_ready, h_d_valid); end
        step();
        dev_d_valid = 1'b0;
        #4;
        total++; if (unexp_rsp !== 1'b1) begin bad++; $display("FAIL unexp_pulse got=%0b want=1", unexp_rsp); end
        step();
        #4;
        total++; if (unexp_rsp !== 1'b0) begin bad++; $display("FAIL unexp_end got=%0b want=0", unexp_rsp); end
        h_a_valid = 2'b01; dev_a_ready = 1'b1;
        #1;
        total++; if (h_a_ready !== 2'b01) begin bad++; $display("FAIL rst_pre_acc got=%b want=01", h_a_ready); end
        step();
        h_a_valid = 2'b00; dev_a_ready = 1'b0;
        #4;
        total++; if (outstanding !== 2'd1) begin bad++; $display("FAIL rst_pre_count got=%0d want=1", outstanding); end
        rst_n = 1'b0;
        step();
        #4;
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", outstanding); end
        rst_n = 1'b1;
        step();
        dev_d_valid = 1'b1;
        #4;
        total++; if (h_d_valid !== 2'b00) begin bad++; $display("FAIL rst_late_rsp got=%b want=00", h_d_valid); end
        step();
        dev_d_valid = 1'b0;
        #4;
        total++; if (unexp_rsp !== 1'b1) begin bad++; $display("FAIL rst_late_unexp got=%0b want=1", unexp_rsp); end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall_lock();
        test_full();
        test_ordering();
        test_unexp_reset();
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
